main_control_fsm: RTL and testbench

- Multicycle MIPS main control unit.
- Sequences fetch, decode, execute, memory and writeback for each instruction, and drives every datapath enable and mux select.
- Sits directly upstream of the ALU control: it produces the 3-bit ULAOp that the ALU control decodes together with funct.
- Also detects illegal opcodes and signed overflow, and redirects the PC to the exception vector.

---
 rtl/main_control_fsm_if.sv | 34 +++
 rtl/main_control_fsm.sv | 201 ++++++++++++++++++++
 tb/tb_main_control_fsm.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/main_control_fsm_if.sv
// Control bundle between the multicycle MIPS main control unit and its datapath.
// master = control unit, slave = datapath side (instruction fields and ALU flags in, controls out).
interface main_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] ula_op;
  logic [1:0] pc_source;
  logic       epc_write;
  logic [1:0] exc_cause;

  modport master (
    input  opcode, funct, zero, overflow,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, ula_op, pc_source, epc_write, exc_cause
  );

  modport slave (
    output opcode, funct, zero, overflow,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, ula_op, pc_source, epc_write, exc_cause
  );
endinterface

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback,
// traps illegal opcodes and signed overflow to the exception vector.
module main_control_fsm #(
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  main_control_fsm_if.master bus
);

  localparam logic [2:0] LAT3 = 3'(MEM_LAT);

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    RESET_ST, FETCH, DECODE, R_EXEC, R_WB, ADDI_EXEC, ANDI_EXEC, XORI_EXEC,
    I_WB, MEM_ADDR, MEM_READ, LOAD_WB, MEM_WRITE, BRANCH, JUMP, EXC
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic [1:0] cause, cause_nxt;
  logic       mem_done;
  logic       trap_r;

  logic       pc_write_c, iord_c, mem_read_c, mem_write_c, ir_write_c;
  logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c, epc_write_c;
  logic [1:0] alu_src_b_c, pc_source_c;
  logic [2:0] ula_op_c;

  assign mem_done = (cnt == LAT3);
  assign trap_r   = ((bus.funct == 6'h20) || (bus.funct == 6'h22)) && bus.overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_ST;
      cnt   <= 3'd0;
      cause <= 2'b00;
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
      // The counter idles at zero, so entry into either memory state starts it cleared.
      if (((state == FETCH) || (state == MEM_READ)) && !mem_done) cnt <= cnt + 3'd1;
      else                                                        cnt <= 3'd0;
    end
  end

  always_comb begin
    state_nxt    = state;
    cause_nxt    = cause;
    pc_write_c   = 1'b0;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    ula_op_c     = 3'b000;
    pc_source_c  = 2'b00;
    epc_write_c  = 1'b0;

    unique case (state)
      RESET_ST: state_nxt = FETCH;
      FETCH: begin
        mem_read_c = 1'b1;
        if (mem_done) begin
          ir_write_c  = 1'b1;
          pc_write_c  = 1'b1;
          alu_src_b_c = 2'b01;
          state_nxt   = DECODE;
        end
      end
      DECODE: begin
        alu_src_b_c = 2'b10;
        case (bus.opcode)
          OP_R:              state_nxt = R_EXEC;
          OP_LW, OP_SW:      state_nxt = MEM_ADDR;
          OP_BEQ, OP_BNE:    state_nxt = BRANCH;
          OP_J:              state_nxt = JUMP;
          OP_ADDI, OP_ADDIU: state_nxt = ADDI_EXEC;
          OP_ANDI:           state_nxt = ANDI_EXEC;
          OP_XORI:           state_nxt = XORI_EXEC;
          default: begin
            state_nxt = EXC;
            cause_nxt = 2'b01;
          end
        endcase
      end
      R_EXEC: begin
        alu_src_a_c = 1'b1;
        ula_op_c    = 3'b010;
        state_nxt   = R_WB;
      end
      R_WB: begin
        reg_dst_c = 1'b1;
        if (trap_r) begin
          state_nxt = EXC;
          cause_nxt = 2'b10;
        end else begin
          reg_write_c = 1'b1;
          state_nxt   = FETCH;
        end
      end
      ADDI_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_nxt   = I_WB;
      end
      ANDI_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b11;
        ula_op_c    = 3'b011;
        state_nxt   = I_WB;
      end
      XORI_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b11;
        ula_op_c    = 3'b100;
        state_nxt   = I_WB;
      end
      I_WB: begin
        // Only addi traps; addiu shares this state but never raises overflow.
        if ((bus.opcode == OP_ADDI) && bus.overflow) begin
          state_nxt = EXC;
          cause_nxt = 2'b10;
        end else begin
          reg_write_c = 1'b1;
          state_nxt   = FETCH;
        end
      end
      MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_nxt   = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        if (mem_done) state_nxt = LOAD_WB;
      end
      LOAD_WB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        state_nxt    = FETCH;
      end
      MEM_WRITE: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        state_nxt   = FETCH;
      end
      BRANCH: begin
        alu_src_a_c = 1'b1;
        ula_op_c    = 3'b001;
        pc_source_c = 2'b01;
        pc_write_c  = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
        state_nxt   = FETCH;
      end
      JUMP: begin
        pc_source_c = 2'b10;
        pc_write_c  = 1'b1;
        state_nxt   = FETCH;
      end
      EXC: begin
        epc_write_c = 1'b1;
        pc_source_c = 2'b11;
        pc_write_c  = 1'b1;
        state_nxt   = FETCH;
      end
      default: state_nxt = RESET_ST;
    endcase
  end

  // Write enables are gated by reset so an aborted instruction never commits.
  assign bus.pc_write   = pc_write_c  & ~reset;
  assign bus.mem_write  = mem_write_c & ~reset;
  assign bus.ir_write   = ir_write_c  & ~reset;
  assign bus.reg_write  = reg_write_c & ~reset;
  assign bus.epc_write  = epc_write_c & ~reset;
  assign bus.iord       = iord_c;
  assign bus.mem_read   = mem_read_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.ula_op     = ula_op_c;
  assign bus.pc_source  = pc_source_c;
  assign bus.exc_cause  = cause;

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: directed table, reset corner cases, and random
// instructions checked cycle by cycle against a per-instruction sequence model.
module tb_main_control_fsm;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic reset;
  main_control_fsm_if bus ();

  main_control_fsm #(.MEM_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] ula_op;
    logic [1:0] pc_source;
    logic       epc_write;
    logic [1:0] exc_cause;
  } outv_t;

  typedef struct {
    logic [5:0] op, fn;
    logic       z, ov;
    int         cyc;
    logic [1:0] cause;
    int         probe;
    logic [2:0] ula;
    logic [1:0] srcb;
    logic       pcw;
  } tab_t;

  int    n_chk = 0;
  int    n_fail = 0;
  outv_t exp_q[$];
  logic [1:0] m_cause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic outv_t sample();
    outv_t o;
    o.pc_write = bus.pc_write;   o.iord = bus.iord;         o.mem_read = bus.mem_read;
    o.mem_write = bus.mem_write; o.ir_write = bus.ir_write; o.reg_dst = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg; o.reg_write = bus.reg_write; o.alu_src_a = bus.alu_src_a;
    o.alu_src_b = bus.alu_src_b; o.ula_op = bus.ula_op;     o.pc_source = bus.pc_source;
    o.epc_write = bus.epc_write; o.exc_cause = bus.exc_cause;
    return o;
  endfunction

  task automatic push(input outv_t v);
    v.exc_cause = m_cause;
    exp_q.push_back(v);
  endtask

  task automatic push_exc(input logic [1:0] c);
    outv_t v = '0;
    m_cause = c;
    v.epc_write = 1'b1; v.pc_source = 2'b11; v.pc_write = 1'b1;
    push(v);
  endtask

  // Expected per-cycle outputs of one whole instruction, starting at its first fetch cycle.
  task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
    outv_t v;
    for (int i = 0; i <= LAT; i++) begin
      v = '0; v.mem_read = 1'b1;
      if (i == LAT) begin v.ir_write = 1'b1; v.pc_write = 1'b1; v.alu_src_b = 2'b01; end
      push(v);
    end
    v = '0; v.alu_src_b = 2'b10; push(v);
    case (op)
      6'h00: begin
        v = '0; v.alu_src_a = 1'b1; v.ula_op = 3'b010; push(v);
        v = '0; v.reg_dst = 1'b1;
        if ((fn == 6'h20 || fn == 6'h22) && ov) begin push(v); push_exc(2'b10); end
        else begin v.reg_write = 1'b1; push(v); end
      end
      6'h08, 6'h09, 6'h0C, 6'h0E: begin
        v = '0; v.alu_src_a = 1'b1;
        v.alu_src_b = (op == 6'h08 || op == 6'h09) ? 2'b10 : 2'b11;
        v.ula_op = (op == 6'h0C) ? 3'b011 : (op == 6'h0E) ? 3'b100 : 3'b000;
        push(v);
        v = '0;
        if (op == 6'h08 && ov) begin push(v); push_exc(2'b10); end
        else begin v.reg_write = 1'b1; push(v); end
      end
      6'h23, 6'h2B: begin
        v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; push(v);
        if (op == 6'h23) begin
          for (int i = 0; i <= LAT; i++) begin v = '0; v.mem_read = 1'b1; v.iord = 1'b1; push(v); end
          v = '0; v.mem_to_reg = 1'b1; v.reg_write = 1'b1; push(v);
        end else begin
          v = '0; v.mem_write = 1'b1; v.iord = 1'b1; push(v);
        end
      end
      6'h04, 6'h05: begin
        v = '0; v.alu_src_a = 1'b1; v.ula_op = 3'b001; v.pc_source = 2'b01;
        v.pc_write = (op == 6'h04) ? z : ~z;
        push(v);
      end
      6'h02: begin v = '0; v.pc_source = 2'b10; v.pc_write = 1'b1; push(v); end
      default: push_exc(2'b01);
    endcase
  endtask

  task automatic run_tab(input tab_t t, input int idx);
    int    n = 0;
    bit    left = 0;
    bit    done = 0;
    outv_t o = '0;
    bus.opcode = t.op; bus.funct = t.fn; bus.zero = t.z; bus.overflow = t.ov;
    while (!done && n < 20) begin
      #1;
      o = sample();
      if (n == t.probe) begin
        chk($sformatf("tab%0d ula_op", idx), 32'(o.ula_op), 32'(t.ula));
        chk($sformatf("tab%0d alu_src_b", idx), 32'(o.alu_src_b), 32'(t.srcb));
        chk($sformatf("tab%0d pc_write", idx), 32'(o.pc_write), 32'(t.pcw));
      end
      if (left && o.mem_read && !o.iord) done = 1;
      else begin
        if (!(o.mem_read && !o.iord)) left = 1;
        n++;
        step();
      end
    end
    chk($sformatf("tab%0d cycles", idx), 32'(n), 32'(t.cyc));
    chk($sformatf("tab%0d exc_cause", idx), 32'(o.exc_cause), 32'(t.cause));
  endtask

  tab_t tab[17];
  logic [5:0] op_pool[11];
  logic [5:0] fn_pool[4];

  initial begin
    outv_t o, e;
    logic [5:0] op, fn;

    tab[0]  = '{6'h00, 6'h21, 1'b0, 1'b0, 5, 2'b00, 3, 3'b010, 2'b00, 1'b0};
    tab[1]  = '{6'h00, 6'h20, 1'b0, 1'b1, 6, 2'b10, 3, 3'b010, 2'b00, 1'b0};
    tab[2]  = '{6'h09, 6'h00, 1'b0, 1'b1, 5, 2'b10, 3, 3'b000, 2'b10, 1'b0};
    tab[3]  = '{6'h3F, 6'h00, 1'b0, 1'b0, 4, 2'b01, 2, 3'b000, 2'b10, 1'b0};
    tab[4]  = '{6'h0E, 6'h00, 1'b0, 1'b0, 5, 2'b01, 3, 3'b100, 2'b11, 1'b0};
    tab[5]  = '{6'h0C, 6'h00, 1'b0, 1'b0, 5, 2'b01, 3, 3'b011, 2'b11, 1'b0};
    tab[6]  = '{6'h23, 6'h00, 1'b0, 1'b0, 7, 2'b01, 5, 3'b000, 2'b00, 1'b0};
    tab[7]  = '{6'h2B, 6'h00, 1'b0, 1'b0, 5, 2'b01, 4, 3'b000, 2'b00, 1'b0};
    tab[8]  = '{6'h04, 6'h00, 1'b1, 1'b0, 4, 2'b01, 3, 3'b001, 2'b00, 1'b1};
    tab[9]  = '{6'h05, 6'h00, 1'b1, 1'b0, 4, 2'b01, 3, 3'b001, 2'b00, 1'b0};
    tab[10] = '{6'h02, 6'h00, 1'b0, 1'b0, 4, 2'b01, 3, 3'b000, 2'b00, 1'b1};
    tab[11] = '{6'h08, 6'h00, 1'b0, 1'b1, 6, 2'b10, 3, 3'b000, 2'b10, 1'b0};
    tab[12] = '{6'h10, 6'h00, 1'b0, 1'b0, 4, 2'b01, 2, 3'b000, 2'b10, 1'b0};
    tab[13] = '{6'h00, 6'h22, 1'b0, 1'b1, 6, 2'b10, 3, 3'b010, 2'b00, 1'b0};
    tab[14] = '{6'h00, 6'h21, 1'b0, 1'b1, 5, 2'b10, 3, 3'b010, 2'b00, 1'b0};
    tab[15] = '{6'h04, 6'h00, 1'b0, 1'b0, 4, 2'b10, 3, 3'b001, 2'b00, 1'b0};
    tab[16] = '{6'h05, 6'h00, 1'b0, 1'b0, 4, 2'b10, 3, 3'b001, 2'b00, 1'b1};
    op_pool = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C, 6'h0E, 6'h23, 6'h2B, 6'h3F};
    fn_pool = '{6'h20, 6'h21, 6'h22, 6'h24};

    // Power-on reset
    reset = 1'b1; bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.overflow = 1'b0;
    step(); step(); step();
    chk("reset outputs", 32'(sample()), 32'd0);
    reset = 1'b0;
    #1;
    chk("reset_st outputs", 32'(sample()), 32'd0);
    step();
    chk("first fetch mem_read", 32'(bus.mem_read), 32'd1);

    for (int i = 0; i < 17; i++) run_tab(tab[i], i);

    // Reset held 3 cycles in the middle of lw's MEM_READ
    bus.opcode = 6'h23; bus.funct = 6'h00; bus.zero = 1'b0; bus.overflow = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("midlw in mem_read", {30'd0, bus.mem_read, bus.iord}, 32'd3);
    reset = 1'b1;
    #1;
    chk("midlw we masked", {27'd0, bus.pc_write, bus.mem_write, bus.ir_write, bus.reg_write, bus.epc_write}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midlw reset cyc%0d", i), 32'(sample()), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("midlw reset_st", 32'(sample()), 32'd0);
    step();
    chk("midlw fetch", {30'd0, bus.mem_read, bus.iord}, 32'd2);
    chk("midlw exc_cause", 32'(bus.exc_cause), 32'd0);

    // Reset during the final fetch cycle must suppress ir_write/pc_write
    step();
    reset = 1'b1;
    #1;
    chk("fetch reset gating", {29'd0, bus.mem_read, bus.ir_write, bus.pc_write}, 32'd4);
    step();
    reset = 1'b0;
    step();

    // Random instructions against the sequence model
    m_cause = 2'b00;
    for (int k = 0; k < 80; k++) begin
      op = ($urandom_range(0, 11) == 11) ? 6'($urandom) : op_pool[$urandom_range(0, 10)];
      fn = ($urandom_range(0, 4) == 4) ? 6'($urandom) : fn_pool[$urandom_range(0, 3)];
      bus.opcode = op; bus.funct = fn;
      bus.zero = 1'($urandom); bus.overflow = 1'($urandom);
      model(op, fn, bus.zero, bus.overflow);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        #1;
        o = sample();
        chk($sformatf("rand%0d op%02h fn%02h z%0d ov%0d", k, op, fn, bus.zero, bus.overflow),
            32'(o), 32'(e));
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
